// File: rtl/divider_pkg.sv
// Shared types and defaults for the restoring divider.
// Holds the FSM state encoding and the default operand width.
package divider_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/full_adder_4bit.sv
// Ripple-style adder used by the divider as a subtractor.
// carry_out = 1 with inverted b and carry_in = 1 means no borrow.
module full_adder_4bit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};

endmodule

// File: rtl/divider_4bit.sv
// Multi-cycle restoring divider, one quotient bit per CALC cycle.
// Divide-by-zero short-circuits straight to DONE with a flag.
module divider_4bit
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo_p;
  logic [WIDTH-1:0] part;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] part_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             carry;
  logic             take;
  logic             accept;
  logic             last;

  assign accept  = start && (state != CALC);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign shifted = {part, dvd[WIDTH-1]};

  full_adder_4bit #(
    .W(WIDTH)
  ) u_sub (
    .a        (shifted[WIDTH-1:0]),
    .b        (~dvs),
    .carry_in (1'b1),
    .sum      (diff),
    .carry_out(carry)
  );

  // Sign bit of the WIDTH+1-bit trial is ~(shifted msb ^ carry);
  // shifted < 2*divisor rules out overflow, so clear sign => take it.
  assign take    = shifted[WIDTH] ^ carry;
  assign part_nx = take ? diff : shifted[WIDTH-1:0];
  assign quo_nx  = {quo_p[WIDTH-2:0], take};

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept)
          state_nx = (divisor == '0) ? DONE : CALC;
        else
          state_nx = IDLE;
      end
      CALC: begin
        if (last)
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo_p       <= '0;
      part        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt   <= '0;
        part  <= '0;
        quo_p <= '0;
        dvd   <= dividend;
        dvs   <= divisor;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        cnt   <= cnt + CW'(1);
        part  <= part_nx;
        quo_p <= quo_nx;
        dvd   <= dvd << 1;
        if (last) begin
          quotient    <= quo_nx;
          remainder   <= part_nx;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_4bit.sv
// Self-checking bench for divider_4bit.
// Directed scenarios, random pairs and a full operand sweep.
module tb_divider_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divider_4bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) nb++;
    end
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic check_result(input string tag, input logic [3:0] a,
                              input logic [3:0] b);
    int eq, er, ez;
    eq = (b == 0) ? 15 : int'(a) / int'(b);
    er = (b == 0) ? int'(a) : int'(a) % int'(b);
    ez = (b == 0) ? 1 : 0;
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    if (b != 0) begin
      check({tag, "_ident"}, int'(quotient) * int'(b) + int'(remainder),
            int'(a));
      check({tag, "_rlt"}, remainder < b, 1);
    end
  endtask

  task automatic do_div(input string tag, input logic [3:0] a,
                        input logic [3:0] b);
    int n, nb, lat;
    lat = (b == 0) ? 1 : 5;
    issue(a, b);
    wait_done(n, nb);
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, nb, lat - 1);
    check_result(tag, a, b);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int n, nb, dcount;
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);

    do_div("d13_3", 4'd13, 4'd3);
    do_div("d15_1", 4'd15, 4'd1);
    do_div("d2_7", 4'd2, 4'd7);
    do_div("d9_0", 4'd9, 4'd0);

    // second start during CALC must be ignored
    issue(4'd12, 4'd5);
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_busy", busy, 1);
    check("ign_hold_q", quotient, 15);
    check("ign_hold_r", remainder, 9);
    wait_done(n, nb);
    check("ign_lat", n, 3);
    check_result("ign", 4'd12, 4'd5);

    // back-to-back start held in the done cycle
    issue(4'd14, 4'd3);
    wait_done(n, nb);
    check("b2b1_lat", n, 5);
    check_result("b2b1", 4'd14, 4'd3);
    dividend = 4'd6;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_done", done, 0);
    wait_done(n, nb);
    check("b2b2_lat", n, 4);
    check_result("b2b2", 4'd6, 4'd4);

    // reset in the second CALC cycle aborts
    issue(4'd11, 4'd2);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1);
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 4'd3;
    divisor  = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy0", busy, 0);
    check("abort_done0", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort_quiet", dcount, 0);
    do_div("d11_2", 4'd11, 4'd2);

    for (int i = 0; i < 20; i++)
      do_div("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_div("sweep", 4'(a), 4'(b));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
